// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: latches per-channel samples during active video and
// commits them to the display buffer during vertical blank, one channel every
// second cycle, in round-robin order starting at rr_ptr.
// Optional feature macro: FRAME_UPDATE_OVERRUN_EN adds ovr_clr / ovr (sticky
// per-channel overrun flags for samples overwritten before being committed).

// Per-channel slice: pending flag, shadow sample and optional overrun flag.
module fus_chan #(
  parameter int DW = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          req,
  input  logic          commit,
  input  logic [DW-1:0] din,
`ifdef FRAME_UPDATE_OVERRUN_EN
  input  logic          ovr_clr,
  output logic          ovr,
`endif
  output logic          pending,
  output logic [DW-1:0] shadow
);

  // A new sample always wins over a same-cycle commit, so it stays pending.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      shadow  <= '0;
    end else if (req) begin
      pending <= 1'b1;
      shadow  <= din;
    end else if (commit) begin
      pending <= 1'b0;
    end
  end

`ifdef FRAME_UPDATE_OVERRUN_EN
  // Sticky overrun: set beats clear when both happen in the same cycle.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) ovr <= 1'b0;
    else      ovr <= (ovr & ~ovr_clr) | (req & pending & ~commit);
  end
`endif

endmodule

module frame_update_scheduler #(
  parameter int NCH = 13,
  parameter int DW  = 12
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] ch_data,
`ifdef FRAME_UPDATE_OVERRUN_EN
  input  logic              ovr_clr,
  output logic [NCH-1:0]    ovr,
`endif
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [NCH-1:0]    gnt,
  output logic              busy,
  output logic              frame_start
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t                  state, state_n;
  logic                    vblnk_d;
  logic                    armed;     // vblnk seen low since reset
  logic [3:0]              sel;
  logic [3:0]              rr_ptr;
  logic [3:0]              pick;
  int                      idx;
  logic [NCH-1:0]          pending;
  logic [NCH-1:0]          commit;
  logic [NCH-1:0][DW-1:0]  shadow;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign commit[i] = (state == WRITE) && (sel == 4'(i));
    fus_chan #(.DW(DW)) u_ch (
      .pclk    (pclk),
      .rst     (rst),
      .req     (req[i]),
      .commit  (commit[i]),
      .din     (ch_data[i*DW +: DW]),
`ifdef FRAME_UPDATE_OVERRUN_EN
      .ovr_clr (ovr_clr),
      .ovr     (ovr[i]),
`endif
      .pending (pending[i]),
      .shadow  (shadow[i])
    );
  end

  // Rotating priority: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (pending[idx]) pick = 4'(idx);
    end
  end

  // Next-state logic; losing vblank mid-scan abandons the frame.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (vblnk && !vblnk_d && armed) state_n = SCAN;
      SCAN:    if (!vblnk)        state_n = IDLE;
               else if (|pending) state_n = WRITE;
               else               state_n = DONE;
      WRITE:   state_n = vblnk ? SCAN : IDLE;
      DONE:    if (!vblnk) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, edge-detect history, selected channel and round-robin pointer.
  // armed blocks a vblank that was already high across reset release from
  // counting as a rising edge.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      vblnk_d <= 1'b0;
      armed   <= 1'b0;
      sel     <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_n;
      vblnk_d <= vblnk;
      armed   <= armed | ~vblnk;
      if (state == SCAN) sel <= pick;
      if (state == WRITE) rr_ptr <= (sel == 4'(NCH - 1)) ? 4'd0 : sel + 4'd1;
    end
  end

  // Commit outputs are decoded from WRITE so reset clears them at once;
  // wr_data reads the shadow before any same-cycle req overwrites it.
  always_comb begin
    wr_en       = (state == WRITE);
    wr_addr     = wr_en ? sel : 4'd0;
    wr_data     = wr_en ? shadow[sel] : '0;
    gnt         = commit;
    busy        = (state == SCAN) || (state == WRITE);
    frame_start = vblnk_d & ~vblnk;
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: directed frame scenarios plus random
// traffic, checked every cycle against a spec-level reference model.
module tb_frame_update_scheduler;
  localparam int NCH = 13;
  localparam int DW  = 12;

  logic              pclk = 1'b0;
  logic              rst = 1'b0;
  logic              vblnk = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic              ovr_clr = 1'b0;
  logic              wr_en, busy, frame_start;
  logic [3:0]        wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NCH-1:0]    gnt;
`ifdef FRAME_UPDATE_OVERRUN_EN
  logic [NCH-1:0]    ovr;
`endif

  frame_update_scheduler #(.NCH(NCH), .DW(DW)) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vblnk       (vblnk),
    .req         (req),
    .ch_data     (ch_data),
`ifdef FRAME_UPDATE_OVERRUN_EN
    .ovr_clr     (ovr_clr),
    .ovr         (ovr),
`endif
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .gnt         (gnt),
    .busy        (busy),
    .frame_start (frame_start)
  );

  always #5 pclk = ~pclk;

  int total = 0, bad = 0, cyc = 0, fs_cnt = 0;
  int lg_cyc[$], lg_addr[$], lg_data[$], lg_gnt[$];

  always @(posedge pclk) cyc++;

  task automatic chk(input string n, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_SCAN, M_WRITE, M_DONE} ph_t;
  ph_t            ph = M_IDLE;
  bit [NCH-1:0]   m_pend = '0, m_ovr = '0, m_po;
  int             m_shadow[NCH];
  int             m_rr = 0, m_sel = 0;
  bit             m_vd = 0, m_seen_low = 0, m_commit;

  // Channel with the smallest forward distance from the round-robin pointer.
  function automatic int pick_ch(input bit [NCH-1:0] p, input int rr);
    int best = -1;
    for (int i = 0; i < NCH; i++)
      if (p[i] && (best < 0 || (i - rr + NCH) % NCH < (best - rr + NCH) % NCH))
        best = i;
    return best;
  endfunction

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ph = M_IDLE; m_pend = '0; m_ovr = '0; m_rr = 0; m_sel = 0;
      m_vd = 0; m_seen_low = 0;
      for (int i = 0; i < NCH; i++) m_shadow[i] = 0;
    end else begin
      m_po = m_pend;
      m_commit = (ph == M_WRITE);
      for (int i = 0; i < NCH; i++) begin
        m_ovr[i] = (m_ovr[i] && !ovr_clr) || (req[i] && m_po[i] && !(m_commit && m_sel == i));
        if (req[i]) begin
          m_pend[i] = 1'b1;
          m_shadow[i] = int'(ch_data[i*DW +: DW]);
        end else if (m_commit && m_sel == i) m_pend[i] = 1'b0;
      end
      case (ph)
        M_IDLE:  if (vblnk && !m_vd && m_seen_low) ph = M_SCAN;
        M_SCAN:  if (!vblnk) ph = M_IDLE;
                 else if (m_po != 0) begin m_sel = pick_ch(m_po, m_rr); ph = M_WRITE; end
                 else ph = M_DONE;
        M_WRITE: begin m_rr = (m_sel + 1) % NCH; ph = vblnk ? M_SCAN : M_IDLE; end
        M_DONE:  if (!vblnk) ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
      m_vd = vblnk;
      m_seen_low = m_seen_low | !vblnk;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           e_w;
  int           e_a, e_d;
  bit [NCH-1:0] e_g;
  always @(negedge pclk) begin
    e_w = (ph == M_WRITE);
    e_a = e_w ? m_sel : 0;
    e_d = e_w ? m_shadow[m_sel] : 0;
    e_g = e_w ? (NCH'(1) << m_sel) : '0;
    chk("wr_en", wr_en, e_w);
    chk("wr_addr", wr_addr, e_a);
    chk("wr_data", wr_data, e_d);
    chk("gnt", gnt, e_g);
    chk("busy", busy, (ph == M_SCAN || ph == M_WRITE));
    chk("frame_start", frame_start, (m_vd && !vblnk));
`ifdef FRAME_UPDATE_OVERRUN_EN
    chk("ovr", ovr, m_ovr);
`endif
    if (wr_en === 1'b1) begin
      lg_cyc.push_back(cyc); lg_addr.push_back(wr_addr);
      lg_data.push_back(wr_data); lg_gnt.push_back(gnt);
    end
    if (frame_start === 1'b1) fs_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [NCH-1:0] r = '0);
    req = r;
    @(posedge pclk); #1;
    req = '0;
  endtask

  task automatic load(input int ch, input int d);
    logic [NCH-1:0] r;
    r = '0; r[ch] = 1'b1;
    ch_data[ch*DW +: DW] = d[DW-1:0];
    step(r);
  endtask

  task automatic vpulse(input int n);
    vblnk = 1'b1;
    repeat (n) step();
    vblnk = 1'b0;
    step(); step();
  endtask

  task automatic clr_log();
    lg_cyc.delete(); lg_addr.delete(); lg_data.delete(); lg_gnt.delete();
  endtask

  int t0, n, mask1, mask2, seg;
  logic [NCH-1:0] r_all;

  initial begin
    // reset state
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    step();

    // single channel commit two cycles after vblank rises
    clr_log();
    load(3, 'h5A5);
    step(); step();
    t0 = cyc;
    vblnk = 1'b1;
    repeat (6) step();
    chk("done_not_busy", busy, 0);
    vblnk = 1'b0;
    step(); step();
    chk("one_cnt", lg_addr.size(), 1);
    if (lg_addr.size() == 1) begin
      chk("one_addr", lg_addr[0], 3);
      chk("one_data", lg_data[0], 'h5A5);
      chk("one_gnt", lg_gnt[0], 'h0008);
      chk("one_time", lg_cyc[0], t0 + 2);
    end

    // round-robin wrap from rr_ptr=6
    load(5, 'h055);
    vpulse(5);
    clr_log();
    load(0, 'h0A0); load(5, 'h0A5); load(12, 'h0AC);
    t0 = cyc;
    vblnk = 1'b1;
    repeat (10) step();
    vblnk = 1'b0;
    step(); step();
    chk("rr_cnt", lg_addr.size(), 3);
    if (lg_addr.size() == 3) begin
      chk("rr_a0", lg_addr[0], 12);
      chk("rr_a1", lg_addr[1], 0);
      chk("rr_a2", lg_addr[2], 5);
      chk("rr_d0", lg_data[0], 'h0AC);
      chk("rr_t1", lg_cyc[1] - lg_cyc[0], 2);
      chk("rr_t2", lg_cyc[2] - lg_cyc[1], 2);
      chk("rr_t0", lg_cyc[0], t0 + 2);
    end
    chk("rr_final", dut.rr_ptr, 6);

    // latest sample wins
    clr_log();
    load(2, 'h111); load(2, 'h222);
`ifdef FRAME_UPDATE_OVERRUN_EN
    chk("ovr2_set", ovr[2], 1);
`endif
    vpulse(6);
    chk("lw_cnt", lg_addr.size(), 1);
    if (lg_addr.size() == 1) chk("lw_data", lg_data[0], 'h222);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
`ifdef FRAME_UPDATE_OVERRUN_EN
    chk("ovr_clr", ovr, 0);
`endif

    // req in the WRITE cycle of the same channel
    clr_log();
    load(7, 'h100);
    vblnk = 1'b1;
    step(); step();
    ch_data[7*DW +: DW] = 12'h333;
    vblnk = 1'b0;
    step(NCH'(1) << 7);
    step(); step(); step();
    chk("wc_cnt", lg_addr.size(), 1);
    if (lg_addr.size() == 1) chk("wc_old", lg_data[0], 'h100);
    clr_log();
    vpulse(6);
    chk("wc2_cnt", lg_addr.size(), 1);
    if (lg_addr.size() == 1) chk("wc2_new", lg_data[0], 'h333);

    // vblank ends after three commits
    clr_log();
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = DW'(i * 16 + 1);
    r_all = '1;
    step(r_all);
    fs_cnt = 0;
    vblnk = 1'b1;
    repeat (6) step();
    vblnk = 1'b0;
    repeat (4) step();
    chk("cut_cnt", lg_addr.size(), 3);
    chk("cut_fs", fs_cnt, 1);
    mask1 = 0;
    foreach (lg_addr[i]) mask1 |= 1 << lg_addr[i];
    clr_log();
    vpulse(30);
    chk("rest_cnt", lg_addr.size(), 10);
    mask2 = 0;
    foreach (lg_addr[i]) mask2 |= 1 << lg_addr[i];
    chk("rest_mask", mask1 | mask2, 'h1FFF);
    chk("rest_disj", mask1 & mask2, 0);

    // asynchronous reset in the middle of a WRITE
    load(4, 'h444); load(9, 'h999);
    vblnk = 1'b1;
    n = 0;
    while (wr_en !== 1'b1 && n < 10) begin step(); n++; end
    chk("wr_seen", (n < 10), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_wr_en", wr_en, 0);
    chk("ar_addr", wr_addr, 0);
    chk("ar_data", wr_data, 0);
    chk("ar_gnt", gnt, 0);
    chk("ar_busy", busy, 0);
    chk("ar_fs", frame_start, 0);
    @(posedge pclk); @(posedge pclk); #1;
    rst = 1'b1;
    clr_log();
    load(6, 'h666);
    repeat (5) step();
    chk("ar_quiet", lg_addr.size(), 0);
    vblnk = 1'b0;
    step(); step();
    vpulse(5);
    chk("ar_resume", lg_addr.size(), 1);
    if (lg_addr.size() == 1) chk("ar_res_addr", lg_addr[0], 6);

    // random traffic against the model
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        vblnk = ~vblnk;
        seg = $urandom_range(1, vblnk ? 24 : 12);
      end
      seg--;
      for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = DW'($urandom);
      ovr_clr = ($urandom_range(0, 15) == 0);
      step(NCH'($urandom & $urandom & $urandom));
    end
    ovr_clr = 1'b0;
    vblnk = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 13, meaning the number of display channels (requesters).
REQ-002 The block SHALL have parameter DW, default 12, meaning the per-channel sample width in bits.
REQ-003 Port pclk  input  1  the single pixel clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 Port vblnk  input  1  vertical blank from the 800x600 timing generator, synchronous to pclk.
REQ-006 Port req  input  NCH  per-channel update strobe, one pclk pulse per new sample.
REQ-007 Port ch_data  input  NCH*DW  flattened samples; channel i occupies bits [i*DW +: DW].
REQ-008 Port wr_en  output  1  display-buffer write strobe.
REQ-009 Port wr_addr  output  4  channel index written.
REQ-010 Port wr_data  output  DW  sample written.
REQ-011 Port gnt  output  NCH  one-hot commit acknowledge, coincident with wr_en.
REQ-012 Port busy  output  1  high while the FSM is in SCAN or WRITE.
REQ-013 Port frame_start  output  1  one-cycle pulse on vblnk falling edge.

Function
REQ-014 The block SHALL hold one pending bit and one DW-bit shadow register per channel; req[i]=1 sets pending[i] and loads shadow[i] from ch_data slice i.
REQ-015 A req on an already-pending channel SHALL overwrite shadow[i]; latest sample wins.
REQ-016 The FSM SHALL have states IDLE, SCAN, WRITE, DONE; encoding is free.
REQ-017 IDLE -> SCAN SHALL occur on the cycle after vblnk is sampled high while the registered vblnk_d is low.
REQ-018 In SCAN, if any pending bit is set, the FSM SHALL select the lowest pending index at or after rr_ptr (wrapping NCH-1 -> 0), latch it, and go to WRITE; else go to DONE.
REQ-019 In WRITE, wr_en, gnt[sel], wr_addr=sel and wr_data=shadow[sel] SHALL be high or valid for exactly one cycle, pending[sel] SHALL clear, and rr_ptr SHALL become sel+1 mod NCH.
REQ-020 WRITE -> SCAN if vblnk=1, else WRITE -> IDLE; commits SHALL occur at most every second cycle.
REQ-021 DONE -> IDLE SHALL occur when vblnk=0; DONE SHALL ignore new pending bits until the next vblank.
REQ-022 A req[sel] in the same cycle as its WRITE SHALL leave pending[sel] set and shadow[sel] holding the new sample; wr_data SHALL carry the old sample.
REQ-023 If vblnk falls during SCAN, the FSM SHALL go to IDLE without writing; uncommitted channels SHALL stay pending for the next frame.
REQ-024 frame_start SHALL pulse for one cycle when vblnk_d=1 and vblnk=0, independent of FSM state.
REQ-025 rr_ptr SHALL persist across frames.

Reset
REQ-026 While rst=0, the block SHALL force the state to IDLE and clear all pending bits, shadows, rr_ptr, vblnk_d, wr_en, wr_addr, wr_data, gnt, busy and frame_start to 0.
REQ-027 A reset asserted mid-WRITE SHALL drop the in-flight commit; there SHALL be no wr_en until the next vblank rising edge after release.

Configuration
REQ-028 With FRAME_UPDATE_OVERRUN_EN defined, the block SHALL add input ovr_clr (1 bit) and output ovr (NCH bits).
REQ-029 ovr[i] SHALL be set sticky when req[i] arrives while pending[i]=1 and no same-cycle commit of i occurs.
REQ-030 ovr SHALL clear synchronously on ovr_clr=1; a set and a clear in the same cycle SHALL leave the bit set.
REQ-031 Without FRAME_UPDATE_OVERRUN_EN, the ports and logic of REQ-028..030 SHALL be absent.

Verification
REQ-032 Bench: req[3] with data 0x5A5 during active video, then vblnk rises at cycle T -> single wr_en at T+2 with wr_addr=3, wr_data=0x5A5, gnt=0x0008; then DONE.
REQ-033 Bench: req on channels 0, 5 and 12 with rr_ptr=6 -> commits in order 12, 0, 5, two cycles apart; final rr_ptr=6.
REQ-034 Bench: req[2] with 0x111 then 0x222 before vblank -> exactly one commit of 0x222; ovr[2]=1 when FRAME_UPDATE_OVERRUN_EN is defined.
REQ-035 Bench: req[7] with 0x333 in the WRITE cycle of channel 7, which carries 0x100 -> wr_data=0x100; the next vblank commits 0x333.
REQ-036 Bench: 13 pending channels with vblnk dropped after 3 commits -> exactly 3 writes; frame_start pulses once; the remaining 10 commit in the next vblank.
REQ-037 Bench: rst=0 asserted in mid-WRITE -> all outputs 0 asynchronously; after release, no wr_en until the next vblank rising edge.
